// File: rtl/demux_tdm_pkg.sv
// Shared types and constants for the 8-slot TDM receiver.
package demux_tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int NUM_SLOTS = 8;
  localparam int SLOT_BITS = 3;
  localparam logic [SLOT_BITS-1:0] LAST_SLOT = 3'd7;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: wraps 7 -> 0 on increment, with load-to-1 and clear-to-0.
module tdm_slot_counter
  import demux_tdm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic                 clear,
  output logic [SLOT_BITS-1:0] slot,
  output logic                 is_last
);

  // Slot register; clear beats load beats increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= 3'd0;
    end else if (clear) begin
      slot <= 3'd0;
    end else if (load) begin
      slot <= 3'd1;
    end else if (en) begin
      slot <= slot + 3'd1;
    end else begin
      slot <= slot;
    end
  end

  assign is_last = (slot == LAST_SLOT);

endmodule

// File: rtl/demux_8_tdm_rx.sv
// 1:8 TDM receiver: locks on the frame marker, gathers slots into shadow
// registers and publishes a whole frame on ch with a one-cycle valid pulse.
module demux_8_tdm_rx
  import demux_tdm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [W-1:0]           din,
  input  logic                   frame,
  output logic [NUM_SLOTS*W-1:0] ch,
  output logic                   valid,
  output logic [SLOT_BITS-1:0]   slot,
  output logic                   locked,
  output logic                   sync_err
);

  state_t                          state;
  logic [NUM_SLOTS-2:0][W-1:0]     shadow;
  logic                            cnt_load;
  logic                            cnt_clear;
  logic                            cnt_inc;
  logic                            is_last;

  tdm_slot_counter u_slot_counter (
    .clk     (clk),
    .rst     (rst),
    .en      (cnt_inc),
    .load    (cnt_load),
    .clear   (cnt_clear),
    .slot    (slot),
    .is_last (is_last)
  );

  // Slot counter steering; any marker (even an early one) restarts at slot 1.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    if (en) begin
      case (state)
        HUNT: begin
          cnt_load = frame;
        end
        LOCKED: begin
          if (frame) begin
            cnt_load = 1'b1;
          end else if (slot == 3'd0) begin
            cnt_clear = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: begin
          cnt_clear = 1'b1;
        end
      endcase
    end else begin
      cnt_load  = 1'b0;
      cnt_clear = 1'b0;
      cnt_inc   = 1'b0;
    end
  end

  // Framing FSM, shadow capture and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      locked   <= 1'b0;
      shadow   <= '0;
      ch       <= '0;
      valid    <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      valid    <= 1'b0;
      sync_err <= 1'b0;
      if (en) begin
        case (state)
          HUNT: begin
            if (frame) begin
              shadow[0] <= din;
              state     <= LOCKED;
              locked    <= 1'b1;
            end else begin
              state <= HUNT;
            end
          end
          LOCKED: begin
            if (frame) begin
              // Early marker drops the partial frame but keeps lock.
              shadow[0] <= din;
              sync_err  <= (slot != 3'd0);
            end else if (slot == 3'd0) begin
              sync_err <= 1'b1;
              state    <= HUNT;
              locked   <= 1'b0;
            end else if (is_last) begin
              ch    <= {din, shadow};
              valid <= 1'b1;
            end else begin
              shadow[slot] <= din;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end else begin
        state <= state;
      end
    end
  end

endmodule

// File: tb/tb_demux_8_tdm_rx.sv
// Directed, table-driven bench for demux_8_tdm_rx (W=1 table, W=4 sequence).
module tb_demux_8_tdm_rx;

  typedef struct {
    logic       rst;
    logic       en;
    logic       frame;
    logic       din;
    logic       exp_valid;
    logic [7:0] exp_ch;
    logic [2:0] exp_slot;
    logic       exp_locked;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        frame = 1'b0;
  logic [0:0]  din = 1'b0;
  logic [7:0]  ch;
  logic        valid;
  logic [2:0]  slot;
  logic        locked;
  logic        sync_err;

  logic        rst4 = 1'b1;
  logic        en4 = 1'b0;
  logic        frame4 = 1'b0;
  logic [3:0]  din4 = 4'h0;
  logic [31:0] ch4;
  logic        valid4;
  logic [2:0]  slot4;
  logic        locked4;
  logic        sync_err4;

  always #5 clk = ~clk;

  demux_8_tdm_rx #(.W(1)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .frame(frame),
    .ch(ch), .valid(valid), .slot(slot), .locked(locked), .sync_err(sync_err)
  );

  demux_8_tdm_rx #(.W(4)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .din(din4), .frame(frame4),
    .ch(ch4), .valid(valid4), .slot(slot4), .locked(locked4), .sync_err(sync_err4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_row(input logic r, input logic e, input logic f, input logic d,
                          input logic v, input logic [7:0] c, input logic [2:0] s,
                          input logic l, input logic er);
    vec_t t;
    t.rst = r; t.en = e; t.frame = f; t.din = d;
    t.exp_valid = v; t.exp_ch = c; t.exp_slot = s; t.exp_locked = l; t.exp_err = er;
    vecs.push_back(t);
  endtask

  // Locked slots first..last of a frame carrying data (bit k = channel k).
  task automatic push_slots(input logic [7:0] data, input int first, input int last,
                            input logic [7:0] prev, input logic err_first);
    for (int k = first; k <= last; k++) begin
      push_row(1'b0, 1'b1, (k == 0), data[k], (k == 7), (k == 7) ? data : prev,
               3'(k + 1), 1'b1, err_first && (k == first));
    end
  endtask

  // Same frame with an idle (en=0) cycle before every slot; idle cycles carry junk.
  task automatic push_gapped(input logic [7:0] data, input logic [7:0] prev);
    for (int k = 0; k < 8; k++) begin
      push_row(1'b0, 1'b0, 1'b1, ~data[k], 1'b0, prev, 3'(k), 1'b1, 1'b0);
      push_row(1'b0, 1'b1, (k == 0), data[k], (k == 7), (k == 7) ? data : prev,
               3'(k + 1), 1'b1, 1'b0);
    end
  endtask

  task automatic step4(input logic r, input logic e, input logic f, input logic [3:0] d);
    @(negedge clk);
    rst4 = r; en4 = e; frame4 = f; din4 = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // W=1 vector table
    push_row(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    push_slots(8'h4D, 0, 7, 8'h00, 1'b0);
    push_slots(8'hA5, 0, 7, 8'h4D, 1'b0);
    push_slots(8'h3C, 0, 7, 8'hA5, 1'b0);
    push_gapped(8'h96, 8'h3C);
    push_slots(8'h0F, 0, 3, 8'h96, 1'b0);
    push_slots(8'hC3, 0, 7, 8'h96, 1'b1);
    push_row(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, 3'd0, 1'b0, 1'b1);
    push_row(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, 3'd0, 1'b0, 1'b0);
    push_row(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, 3'd0, 1'b0, 1'b0);
    push_slots(8'h5A, 0, 7, 8'hC3, 1'b0);
    push_slots(8'hFF, 0, 4, 8'h5A, 1'b0);
    push_row(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    push_row(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    push_slots(8'h81, 0, 7, 8'h00, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; en = vecs[i].en; frame = vecs[i].frame; din = vecs[i].din;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d valid", i), {31'd0, valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("row%0d ch", i), {24'd0, ch}, {24'd0, vecs[i].exp_ch});
      chk($sformatf("row%0d slot", i), {29'd0, slot}, {29'd0, vecs[i].exp_slot});
      chk($sformatf("row%0d locked", i), {31'd0, locked}, {31'd0, vecs[i].exp_locked});
      chk($sformatf("row%0d sync_err", i), {31'd0, sync_err}, {31'd0, vecs[i].exp_err});
    end
    @(negedge clk);
    en = 1'b0;

    // W=4: nibble placement, then missing marker and relock
    step4(1'b1, 1'b0, 1'b0, 4'h0);
    chk("w4 reset ch", ch4, 32'h0);
    chk("w4 reset locked", {31'd0, locked4}, 32'd0);
    for (int k = 0; k < 8; k++) step4(1'b0, 1'b1, (k == 0), 4'(k + 1));
    chk("w4 frame1 valid", {31'd0, valid4}, 32'd1);
    chk("w4 frame1 ch", ch4, 32'h8765_4321);
    step4(1'b0, 1'b1, 1'b0, 4'h9);
    chk("w4 missing sync_err", {31'd0, sync_err4}, 32'd1);
    chk("w4 missing locked", {31'd0, locked4}, 32'd0);
    chk("w4 missing valid", {31'd0, valid4}, 32'd0);
    step4(1'b0, 1'b1, 1'b0, 4'hA);
    step4(1'b0, 1'b1, 1'b0, 4'hB);
    chk("w4 hunt slot", {29'd0, slot4}, 32'd0);
    chk("w4 hunt sync_err", {31'd0, sync_err4}, 32'd0);
    chk("w4 hunt ch hold", ch4, 32'h8765_4321);
    for (int k = 0; k < 8; k++) begin
      step4(1'b0, 1'b1, (k == 0), 4'(15 - k));
      if (k == 0) chk("w4 relock locked", {31'd0, locked4}, 32'd1);
    end
    chk("w4 frame2 valid", {31'd0, valid4}, 32'd1);
    chk("w4 frame2 ch", ch4, 32'h89AB_CDEF);
    step4(1'b0, 1'b0, 1'b0, 4'h0);
    chk("w4 valid pulse ends", {31'd0, valid4}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
